// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
//  Module      : pc_fetch_unit_if
//  Description : Decoder-side control and PC/statistics bus for pc_fetch_unit.
//                The master drives decoder decisions; the slave is the unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if #(
  parameter int CNT_W = 16
);
  // Decoder decisions for the instruction currently at out_pc
  logic [31:0]      in_is;
  logic             in_J;
  logic             in_JW;
  logic             in_JR;
  logic             in_BEQ;
  logic             in_BNE;
  logic             in_BGEZ;
  logic             in_equal;
  logic [31:0]      in_rs;
  logic             in_halt;
  logic             in_go;
  logic             in_clr_stats;

  // PC and front-panel statistics
  logic [31:0]      out_pc;
  logic [31:0]      out_pc_plus4;
  logic             out_halted;
  logic [31:0]      out_cycles;
  logic [CNT_W-1:0] out_jumps;
  logic [CNT_W-1:0] out_branches;

  modport master (
    output in_is, in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ,
           in_equal, in_rs, in_halt, in_go, in_clr_stats,
    input  out_pc, out_pc_plus4, out_halted, out_cycles,
           out_jumps, out_branches
  );

  modport slave (
    input  in_is, in_J, in_JW, in_JR, in_BEQ, in_BNE, in_BGEZ,
           in_equal, in_rs, in_halt, in_go, in_clr_stats,
    output out_pc, out_pc_plus4, out_halted, out_cycles,
           out_jumps, out_branches
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program counter and next-PC selection with a RUN/HALT state
//                machine for the exit syscall, plus cycle / jump / taken
//                branch statistics counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  wire logic        in_clk,
  input  wire logic        in_rst_n,
  pc_fetch_unit_if.slave   bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc4;
  logic [31:0]      br_off;
  logic             br_taken;
  logic             sel_jump;
  logic             sel_branch;
  logic [31:0]      cycles_q;
  logic [CNT_W-1:0] jumps_q;
  logic [CNT_W-1:0] branches_q;

  // Opcode bits and the low rs bits never influence the PC.
  logic unused_bits;
  assign unused_bits = ^{bus.in_is[31:26], bus.in_rs[1:0]};

  assign pc4      = pc_q + 32'd4;
  assign br_off   = {{14{bus.in_is[15]}}, bus.in_is[15:0], 2'b00};
  assign br_taken = (bus.in_BEQ  &  bus.in_equal)
                  | (bus.in_BNE  & ~bus.in_equal)
                  | (bus.in_BGEZ & ~bus.in_rs[31]);

  // State register: RUN/HALT
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt syscall stops the unit, go resumes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (bus.in_halt) state_d = S_HALT;
      S_HALT:  if (bus.in_go)   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Next-PC selection in priority order; only in_go matters while halted
  always_comb begin
    pc_d       = pc4;
    sel_jump   = 1'b0;
    sel_branch = 1'b0;
    if (state_q == S_RUN) begin
      if (bus.in_halt) begin
        pc_d = pc_q;
      end else if (bus.in_JR) begin
        pc_d     = {bus.in_rs[31:2], 2'b00};
        sel_jump = 1'b1;
      end else if (bus.in_J | bus.in_JW) begin
        pc_d     = {pc4[31:28], bus.in_is[25:0], 2'b00};
        sel_jump = 1'b1;
      end else if (br_taken) begin
        pc_d       = pc4 + br_off;
        sel_branch = 1'b1;
      end
    end else begin
      // Resume skips past the syscall that caused the halt
      pc_d = bus.in_go ? pc4 : pc_q;
    end
  end

  // PC register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Statistics: clear wins over any increment; jump/branch counts saturate
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cycles_q   <= 32'd0;
      jumps_q    <= '0;
      branches_q <= '0;
    end else if (bus.in_clr_stats) begin
      cycles_q   <= 32'd0;
      jumps_q    <= '0;
      branches_q <= '0;
    end else begin
      if (state_q == S_RUN) begin
        cycles_q <= cycles_q + 32'd1;
      end
      if (sel_jump && (jumps_q != CNT_MAX)) begin
        jumps_q <= jumps_q + 1'b1;
      end
      if (sel_branch && (branches_q != CNT_MAX)) begin
        branches_q <= branches_q + 1'b1;
      end
    end
  end

  assign bus.out_pc       = pc_q;
  assign bus.out_pc_plus4 = pc4;
  assign bus.out_halted   = (state_q == S_HALT);
  assign bus.out_cycles   = cycles_q;
  assign bus.out_jumps    = jumps_q;
  assign bus.out_branches = branches_q;

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage sitting directly upstream of the instruction decoder.
- Holds the PC that addresses instruction ROM.
- Consumes the decoder's jump/branch/syscall decisions for the instruction currently at PC, then selects the next PC.
- Runs a RUN/HALT state machine for the exit syscall, and keeps cycle, jump and taken-branch statistics counters for the front-panel displays.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the jump and taken-branch statistics counters.

Ports:
- in_clk  input  1  system clock; all state updates on rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_is  input  32  instruction word currently fetched at out_pc.
- in_J  input  1  decoder: unconditional jump (J).
- in_JW  input  1  decoder: jump-and-link (JAL).
- in_JR  input  1  decoder: jump register.
- in_BEQ  input  1  decoder: branch if equal.
- in_BNE  input  1  decoder: branch if not equal.
- in_BGEZ  input  1  decoder: branch if rs >= 0.
- in_equal  input  1  ALU/regfile compare: rs == rt.
- in_rs  input  32  register rs value (JR target; bit 31 used by BGEZ).
- in_halt  input  1  decoder syscall AND exit code ($v0 == 10).
- in_go  input  1  resume request while halted (single-cycle pulse or level).
- in_clr_stats  input  1  synchronous clear of all statistics counters.
- out_pc  output  32  current PC (byte address, bits[1:0] always 0).
- out_pc_plus4  output  32  out_pc + 4; link value for JAL.
- out_halted  output  1  1 while in HALT state.
- out_cycles  output  32  RUN-cycle count.
- out_jumps  output  CNT_W  executed unconditional jumps (J, JW, JR).
- out_branches  output  CNT_W  taken conditional branches.

Behaviour:
- Reset (asynchronous, in_rst_n = 0): state = RUN, out_pc = RESET_PC, out_halted = 0, all counters = 0. Reset asserted mid-halt or mid-operation returns to these values immediately.
- pc4 = out_pc + 4, modulo 2^32; PC wrap from 32'hFFFF_FFFC goes to 0.
- Next-PC selection in RUN, in priority order; the first match wins even if several controls are asserted:
  1. in_halt: PC held, state -> HALT.
  2. in_JR: next = {in_rs[31:2], 2'b00}.
  3. in_J | in_JW: next = {pc4[31:28], in_is[25:0], 2'b00}.
  4. Branch taken: target = pc4 + {{14{in_is[15]}}, in_is[15:0], 2'b00}, modulo 2^32. Taken conditions:
     - in_BEQ & in_equal
     - in_BNE & ~in_equal
     - in_BGEZ & ~in_rs[31]
  5. Otherwise next = pc4 (includes an untaken branch).
- State machine:
  - RUN -> HALT on in_halt.
  - HALT -> RUN on in_go, with PC <- pc4 (resume after the syscall).
  - In HALT, all control inputs other than in_go are ignored and PC holds.
  - in_go in RUN has no effect.
- out_halted is registered: it is 1 in the cycle after the halting edge and 0 in the cycle after the resuming edge.
- Latency: one cycle. The decision made at edge N appears on out_pc after edge N.
- Counters: all updates are edge-triggered with in_rst_n high.
  - out_cycles: +1 on every edge where state was RUN, including the halting edge. Wraps modulo 2^32.
  - out_jumps: +1 when rule 2 or 3 is selected. Saturates at 2^CNT_W - 1.
  - out_branches: +1 when rule 4 is selected. Saturates at 2^CNT_W - 1.
  - in_clr_stats has priority over any increment in the same cycle; all three counters go to 0. It does not affect the PC or state.
- Control inputs are only meaningful in RUN. Multiple branch flags simultaneously is a decoder error; the unit still applies the priority order without faulting.

Test Plan:
- Reset: drive in_rst_n = 0 asynchronously mid-cycle with RESET_PC = 32'h3000 -> out_pc = 32'h3000 immediately, counters 0, out_halted = 0. Release and run 3 idle cycles -> out_pc = 32'h300C, out_cycles = 3.
- Jump/JR: at PC 32'h3004 with in_J = 1 and in_is[25:0] = 26'h0000100 -> next PC 32'h0000_0400, out_jumps = 1. Then in_JR = 1 with in_rs = 32'h0000_3023 -> PC 32'h3020, out_jumps = 2.
- Branches: at PC 32'h100 with in_BEQ = 1, in_equal = 1, imm = 16'hFFFE -> PC 32'hFC, out_branches = 1. BNE with in_equal = 1 -> PC 32'h100, counter unchanged. BGEZ with in_rs = 32'h8000_0000 -> not taken.
- Halt/resume: in_halt at PC 32'h200 -> PC stays 32'h200, out_halted = 1 next cycle, out_cycles frozen over 5 cycles, and in_J pulses are ignored. Pulse in_go -> PC 32'h204, out_halted = 0.
- Priority and saturation: in_JR and in_BEQ (taken) together -> JR target used, only out_jumps increments. With CNT_W = 4, 20 taken branches -> out_branches = 15. in_clr_stats together with a taken branch -> out_branches = 0 and the PC still branches.
- Wrap: PC 32'hFFFF_FFFC with no control -> 32'h0000_0000. Reset asserted while in HALT -> RUN, PC = RESET_PC.
